// File: rtl/bkm_pkg.sv
// Shared definitions for the BKM datapath, control step and sequencer.
// Holds the iteration width default, sequencer state codes and format codes.
package bkm_pkg;

  localparam int LOG2N_DEF = 6;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] FMT_FP16 = 2'd0;
  localparam logic [1:0] FMT_FP32 = 2'd1;
  localparam logic [1:0] FMT_FP64 = 2'd2;
  localparam logic [1:0] FMT_FIXP = 2'd3;

endpackage

// File: rtl/bkm_iter_cnt.sv
// Iteration index counter: load (to 0, capturing last_n), increment, clear,
// terminal-count flag. Ports: clk, srst, i_load, i_last_n, i_inc, i_clr, o_n, o_tc.
module bkm_iter_cnt
  import bkm_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_load,
  input  logic [LOG2N-1:0] i_last_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [LOG2N-1:0] o_n,
  output logic             o_tc
);

  logic [LOG2N-1:0] r_n;
  logic [LOG2N-1:0] r_last;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_n    <= '0;
      r_last <= '0;
    end else if (i_clr) begin
      r_n <= '0;
    end else if (i_load) begin
      r_n    <= '0;
      r_last <= i_last_n;
    end else if (i_inc) begin
      r_n <= r_n + 1'b1;
    end
  end

  // Increment is gated by o_tc upstream, so the index never wraps.
  assign o_n  = r_n;
  assign o_tc = (r_n == r_last);

endmodule

// File: rtl/bkm_iter_ctrl.sv
// BKM iteration sequencer: accepts (X_0,Y_0), runs last_n+1 datapath steps
// feeding X/Y back, then offers the final pair. Ports: in_* operand
// handshake, step_* datapath drive/return, out_* result handshake, abort, busy.
module bkm_iter_ctrl
  import bkm_pkg::*;
#(
  parameter int W     = 64,
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [1:0]       in_format,
  input  logic [LOG2N-1:0] in_last_n,
  input  logic [W-1:0]     in_X_0,
  input  logic [W-1:0]     in_Y_0,
  input  logic             abort,
  input  logic [1:0]       dig_d_x_n,
  input  logic [1:0]       dig_d_y_n,
  output logic             step_en,
  output logic             step_mode,
  output logic [1:0]       step_format,
  output logic [LOG2N-1:0] step_n,
  output logic [1:0]       step_d_x_n,
  output logic [1:0]       step_d_y_n,
  output logic [W-1:0]     step_X_n,
  output logic [W-1:0]     step_Y_n,
  input  logic [W-1:0]     step_X_np1,
  input  logic [W-1:0]     step_Y_np1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_X,
  output logic [W-1:0]     out_Y,
  output logic             busy
);

  logic [1:0]   r_state;
  logic         r_mode;
  logic [1:0]   r_format;
  logic [W-1:0] r_X;
  logic [W-1:0] r_Y;
  logic [W-1:0] r_out_X;
  logic [W-1:0] r_out_Y;

  logic w_idle;
  logic w_run;
  logic w_done;
  logic w_accept;
  logic w_tc;

  assign w_idle   = (r_state == S_IDLE);
  assign w_run    = (r_state == S_RUN);
  assign w_done   = (r_state == S_DONE);
  assign w_accept = w_idle & in_valid;

  bkm_iter_cnt #(
    .LOG2N(LOG2N)
  ) u_cnt (
    .clk     (clk),
    .srst    (srst),
    .i_load  (w_accept),
    .i_last_n(in_last_n),
    .i_inc   (w_run & ~abort & ~w_tc),
    .i_clr   (~w_idle & abort),
    .o_n     (step_n),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_format <= '0;
      r_X      <= '0;
      r_Y      <= '0;
      r_out_X  <= '0;
      r_out_Y  <= '0;
    end else begin
      unique case (1'b1)
        w_idle: begin
          if (in_valid) begin
            r_mode   <= in_mode;
            r_format <= in_format;
            r_X      <= in_X_0;
            r_Y      <= in_Y_0;
            r_state  <= S_RUN;
          end
        end
        w_run: begin
          // abort wins even over the final step: no result is captured.
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_X <= step_X_np1;
            r_Y <= step_Y_np1;
            if (w_tc) begin
              r_out_X <= step_X_np1;
              r_out_Y <= step_Y_np1;
              r_state <= S_DONE;
            end
          end
        end
        w_done: begin
          if (abort || out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = w_idle;
  assign busy        = ~w_idle;
  assign step_en     = w_run;
  assign out_valid   = w_done;
  assign step_mode   = r_mode;
  assign step_format = r_format;
  assign step_X_n    = r_X;
  assign step_Y_n    = r_Y;
  assign step_d_x_n  = dig_d_x_n;
  assign step_d_y_n  = dig_d_y_n;
  assign out_X       = r_out_X;
  assign out_Y       = r_out_Y;

endmodule

// File: tb/tb_bkm_iter_ctrl.sv
// Directed bench for bkm_iter_ctrl with a trivial datapath model
// (X+1, Y+2) at W=16, LOG2N=4.
module tb_bkm_iter_ctrl;

  localparam int W = 16;
  localparam int L2 = 4;

  logic          clk = 0;
  logic          srst = 1;
  logic          in_valid = 0;
  logic          in_ready;
  logic          in_mode = 0;
  logic [1:0]    in_format = 0;
  logic [L2-1:0] in_last_n = 0;
  logic [W-1:0]  in_X_0 = 0;
  logic [W-1:0]  in_Y_0 = 0;
  logic          abort = 0;
  logic [1:0]    dig_d_x_n = 0;
  logic [1:0]    dig_d_y_n = 0;
  logic          step_en;
  logic          step_mode;
  logic [1:0]    step_format;
  logic [L2-1:0] step_n;
  logic [1:0]    step_d_x_n;
  logic [1:0]    step_d_y_n;
  logic [W-1:0]  step_X_n;
  logic [W-1:0]  step_Y_n;
  logic [W-1:0]  step_X_np1;
  logic [W-1:0]  step_Y_np1;
  logic          out_valid;
  logic          out_ready = 0;
  logic [W-1:0]  out_X;
  logic [W-1:0]  out_Y;
  logic          busy;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign step_X_np1 = step_X_n + 16'd1;
  assign step_Y_np1 = step_Y_n + 16'd2;

  bkm_iter_ctrl #(.W(W), .LOG2N(L2)) dut (
    .clk(clk), .srst(srst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_format(in_format),
    .in_last_n(in_last_n), .in_X_0(in_X_0), .in_Y_0(in_Y_0),
    .abort(abort),
    .dig_d_x_n(dig_d_x_n), .dig_d_y_n(dig_d_y_n),
    .step_en(step_en), .step_mode(step_mode),
    .step_format(step_format), .step_n(step_n),
    .step_d_x_n(step_d_x_n), .step_d_y_n(step_d_y_n),
    .step_X_n(step_X_n), .step_Y_n(step_Y_n),
    .step_X_np1(step_X_np1), .step_Y_np1(step_Y_np1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_X(out_X), .out_Y(out_Y), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand for one cycle; the caller ensures the DUT is idle.
  task automatic start(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [L2-1:0] l, input logic m,
                       input logic [1:0] f);
    in_X_0 = x;
    in_Y_0 = y;
    in_last_n = l;
    in_mode = m;
    in_format = f;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    srst = 1;
    tick();
    tick();
    srst = 0;
    n_tests++;
    if ({in_ready, busy, step_en, out_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags rdy/busy/en/ov=%b want 1000",
               {in_ready, busy, step_en, out_valid});
    end
    n_tests++;
    if ({step_n, step_X_n, step_Y_n, out_X, out_Y} !== '0) begin
      n_fail++;
      $display("FAIL reset_data n=%0d X=%0d Y=%0d oX=%0d oY=%0d want 0",
               step_n, step_X_n, step_Y_n, out_X, out_Y);
    end
    n_tests++;
    if ({step_mode, step_format} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_latch mode/fmt=%b want 000",
               {step_mode, step_format});
    end
  endtask

  task automatic test_full_run();
    int bad = 0;
    start(16'd100, 16'd200, 4'd15, 1'b1, 2'd2);
    for (int i = 0; i < 16; i++) begin
      dig_d_x_n = 2'(i);
      dig_d_y_n = 2'(3 - (i % 4));
      #1;
      if (step_en !== 1'b1 || step_n !== 4'(i) ||
          step_X_n !== 16'(100 + i) || step_Y_n !== 16'(200 + 2 * i) ||
          in_ready !== 1'b0) begin
        bad++;
        $display("FAIL full_step i=%0d en=%b n=%0d X=%0d Y=%0d rdy=%b",
                 i, step_en, step_n, step_X_n, step_Y_n, in_ready);
      end
      if (step_d_x_n !== 2'(i) || step_d_y_n !== 2'(3 - (i % 4))) begin
        bad++;
        $display("FAIL digit_pass i=%0d dx=%0d dy=%0d", i,
                 step_d_x_n, step_d_y_n);
      end
      tick();
    end
    n_tests++;
    if (bad != 0) n_fail++;
    n_tests++;
    if (step_en !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_done en=%b ov=%b want 0 1", step_en, out_valid);
    end
    n_tests++;
    if (out_X !== 16'd116 || out_Y !== 16'd232) begin
      n_fail++;
      $display("FAIL full_result X=%0d Y=%0d want 116 232", out_X, out_Y);
    end
    n_tests++;
    if (step_mode !== 1'b1 || step_format !== 2'd2) begin
      n_fail++;
      $display("FAIL full_latch mode=%b fmt=%0d want 1 2",
               step_mode, step_format);
    end
  endtask

  task automatic test_hold();
    int bad = 0;
    in_valid = 1;
    in_X_0 = 16'd999;
    in_last_n = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_X !== 16'd116 || out_Y !== 16'd232 ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL hold i=%0d ov=%b X=%0d Y=%0d rdy=%b", i,
                 out_valid, out_X, out_Y, in_ready);
      end
    end
    in_valid = 0;
    n_tests++;
    if (bad != 0) n_fail++;
    out_ready = 1;
    tick();
    out_ready = 0;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release rdy=%b ov=%b busy=%b want 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_single();
    start(16'd5, 16'd9, 4'd0, 1'b0, 2'd1);
    n_tests++;
    if (step_en !== 1'b1 || step_n !== 4'd0) begin
      n_fail++;
      $display("FAIL single_step en=%b n=%0d want 1 0", step_en, step_n);
    end
    tick();
    n_tests++;
    if (step_en !== 1'b0 || out_valid !== 1'b1 ||
        out_X !== 16'd6 || out_Y !== 16'd11) begin
      n_fail++;
      $display("FAIL single_result en=%b ov=%b X=%0d Y=%0d want 0 1 6 11",
               step_en, out_valid, out_X, out_Y);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_abort();
    int bad = 0;
    start(16'd100, 16'd200, 4'd15, 1'b0, 2'd0);
    repeat (7) tick();
    n_tests++;
    if (step_n !== 4'd7) begin
      n_fail++;
      $display("FAIL abort_pos n=%0d want 7", step_n);
    end
    abort = 1;
    tick();
    abort = 0;
    n_tests++;
    if (step_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_mid en=%b busy=%b rdy=%b want 0 0 1",
               step_en, busy, in_ready);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL abort_noresult ov high %0d cycles want 0", bad);
    end
    start(16'd1, 16'd1, 4'd2, 1'b0, 2'd0);
    tick();
    tick();
    abort = 1;
    tick();
    abort = 0;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_X !== 16'd6) begin
      n_fail++;
      $display("FAIL abort_last ov=%b busy=%b oX=%0d want 0 0 6",
               out_valid, busy, out_X);
    end
    start(16'd40, 16'd0, 4'd0, 1'b0, 2'd0);
    tick();
    abort = 1;
    out_ready = 1;
    tick();
    abort = 0;
    out_ready = 0;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_done ov=%b busy=%b rdy=%b want 0 0 1",
               out_valid, busy, in_ready);
    end
  endtask

  task automatic test_srst();
    start(16'd100, 16'd200, 4'd15, 1'b1, 2'd3);
    repeat (3) tick();
    srst = 1;
    tick();
    srst = 0;
    n_tests++;
    if (step_en !== 1'b0 || step_n !== 4'd0 || step_X_n !== 16'd0 ||
        in_ready !== 1'b1 || step_mode !== 1'b0 || step_format !== 2'd0 ||
        out_X !== 16'd0) begin
      n_fail++;
      $display("FAIL srst_run en=%b n=%0d X=%0d rdy=%b m=%b f=%0d oX=%0d",
               step_en, step_n, step_X_n, in_ready, step_mode,
               step_format, out_X);
    end
    start(16'd20, 16'd30, 4'd1, 1'b1, 2'd1);
    tick();
    tick();
    srst = 1;
    tick();
    srst = 0;
    n_tests++;
    if (out_valid !== 1'b0 || out_X !== 16'd0 || out_Y !== 16'd0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL srst_done ov=%b X=%0d Y=%0d busy=%b want 0 0 0 0",
               out_valid, out_X, out_Y, busy);
    end
    start(16'd7, 16'd8, 4'd3, 1'b0, 2'd0);
    repeat (4) tick();
    n_tests++;
    if (out_valid !== 1'b1 || out_X !== 16'd11 || out_Y !== 16'd16) begin
      n_fail++;
      $display("FAIL srst_after ov=%b X=%0d Y=%0d want 1 11 16",
               out_valid, out_X, out_Y);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int bad = 0;
    int res_seen = 0;
    in_X_0 = 16'd0;
    in_Y_0 = 16'd0;
    in_last_n = 4'd2;
    in_valid = 1;
    out_ready = 1;
    for (int c = 0; c < 30; c++) begin
      if (in_ready === 1'b1) acc.push_back(c);
      if (out_valid === 1'b1) begin
        res_seen++;
        if (out_X !== 16'd3 || out_Y !== 16'd6) begin
          bad++;
          $display("FAIL b2b_result c=%0d X=%0d Y=%0d want 3 6",
                   c, out_X, out_Y);
        end
      end
      tick();
    end
    in_valid = 0;
    n_tests++;
    if (acc.size() < 3) begin
      n_fail++;
      $display("FAIL b2b_count accepts=%0d want >=3", acc.size());
    end else begin
      for (int i = 1; i < acc.size(); i++)
        if (acc[i] - acc[i-1] != 5) bad++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL b2b_spacing gap0=%0d want 5", acc[1] - acc[0]);
      end
    end
    n_tests++;
    if (res_seen < 5) begin
      n_fail++;
      $display("FAIL b2b_results seen=%0d want >=5", res_seen);
    end
    for (int i = 0; i < 20 && busy !== 1'b0; i++) tick();
    out_ready = 0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain busy=%b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_run();
    test_hold();
    test_single();
    test_abort();
    test_srst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bkm_iter_ctrl.md
# bkm_iter_ctrl

Iteration sequencer for the BKM datapath. It accepts one operand pair (X_0, Y_0) through a valid/ready handshake and drives the single-step datapath (bkm_data_step) for a programmable number of iterations. Per-step digits d_x_n/d_y_n come from the control-step block and are passed through. Each X_np1/Y_np1 is fed back as the next X_n/Y_n, and the final pair is presented on a result handshake. It sits between the FPU operand front-end and the BKM step hardware.

## Interface
- W, 64, datapath word width
- LOG2N, 6, width of iteration index; maximum iterations 2**LOG2N
- clk  in  1  clock, rising edge
- srst  in  1  reset srst, synchronous, active-high; clock clk
- in_valid  in  1  operand offer
- in_ready  out  1  controller can accept an operand
- in_mode  in  1  BKM mode (E/L), latched on accept
- in_format  in  2  number format, latched on accept
- in_last_n  in  LOG2N  index of final iteration; iterations = in_last_n+1
- in_X_0, in_Y_0  in  W each  initial operands
- abort  in  1  cancel operation in progress
- dig_d_x_n, dig_d_y_n  in  2 each  digits for current step from control step
- step_en  out  1  datapath step active this cycle
- step_mode  out  1  latched mode
- step_format  out  2  latched format
- step_n  out  LOG2N  current iteration index
- step_d_x_n, step_d_y_n  out  2 each  digits forwarded to datapath
- step_X_n, step_Y_n  out  W each  current operands to datapath
- step_X_np1, step_Y_np1  in  W each  datapath results, combinational from step_* same cycle
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_X, out_Y  out  W each  final results
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - in_valid&in_ready: latch mode, format, last_n, X_reg<=in_X_0, Y_reg<=in_Y_0, n<=0; go RUN.
- RUN: step_en=1; step_X_n/Y_n = X_reg/Y_reg; step_n = n; step_d_* = dig_d_* (combinational pass-through).
  - Each cycle: X_reg<=step_X_np1, Y_reg<=step_Y_np1.
  - n<last_n: n<=n+1.
  - n==last_n: out_X/out_Y<=step_X_np1/step_Y_np1; go DONE.
- DONE: out_valid=1; out_X/out_Y held stable.
  - out_ready: go IDLE (out_valid low next cycle).
- abort in RUN or DONE: go IDLE next cycle, step_en low, out_valid low, no result delivered. abort in IDLE has no effect.
- abort has priority over every transition in the same cycle, including the last step and out_ready.
- in_ready=0 outside IDLE; in_valid ignored there.
- n never wraps: last_n = 2**LOG2N-1 is legal and runs the full 2**LOG2N steps.
- last_n=0: exactly one step.
- Unsigned LOG2N-bit counter; W-bit data, no width change.
- Reset values:
  - state IDLE, in_ready 1, busy 0.
  - step_en 0, step_n 0, step_X_n/Y_n 0.
  - out_valid 0, out_X/out_Y 0.
  - latched mode/format/last_n 0.
- srst mid-operation: same as reset, with no result delivered.

## Timing
- Accept at edge k (in_valid&in_ready sampled high): step_en high cycles k+1..k+L+1, L=last_n.
- step_n = 0..L in those cycles.
- out_valid high from cycle k+L+2 until the out_ready edge.
- in_ready high from the cycle after out_ready is sampled.
- Throughput: one operation per L+3 cycles with out_ready tied high.
- All outputs are registered except the step_d_* pass-through and step_X_n/Y_n, which are register-driven.

## Structure
- Shared package bkm_pkg:
  - LOG2N default.
  - State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - in_format encodings shared with bkm_data_step/bkm_control_step.
- One sub-module: bkm_iter_cnt (LOG2N counter with load, increment, terminal-count compare against last_n, and clear).
- bkm_data_step is instantiated by the parent, not inside this block.

## Test plan
- W=16, LOG2N=4, datapath model X_np1=X_n+1, Y_np1=Y_n+2; X_0=100, Y_0=200, last_n=15 -> 16 step_en cycles, step_n 0..15, out_X=116, out_Y=232, out_valid at accept+17.
- last_n=0, X_0=5 -> single step_en cycle, out_X=6; last_n=15 -> n reaches 15, no wrap, no 17th step.
- out_ready held low 10 cycles in DONE -> out_valid and out_X/out_Y stable; in_ready=0; in_valid offers ignored; out_ready=1 -> in_ready=1 next cycle.
- abort at step_n=7 -> IDLE next cycle, step_en=0, out_valid never asserts. abort coincident with last step -> no result. abort coincident with out_ready in DONE -> IDLE.
- srst asserted at step_n=3 and in DONE -> all outputs at reset values next cycle. A new operand accepted afterwards completes correctly.
- Back-to-back operations with out_ready=1 and in_valid=1 -> accepts spaced L+3 cycles. dig_d_x_n/dig_d_y_n toggling 0..3 appear unregistered on step_d_* during RUN.
